// File: rtl/ahb_manager_arbiter_if.sv
// Client request/response bundle plus AHB-Lite manager signals for ahb_manager_arbiter.
// req_lock and HMASTLOCK exist only when AHB_MANAGER_ARBITER_LOCK_EN is defined.
`timescale 1ns/1ps
interface ahb_manager_arbiter_if #(
  parameter int NumRequesters = 2,
  parameter int AddressWidth  = 32,
  parameter int DataWidth     = 32
);
  logic [NumRequesters-1:0]              req_valid;
  logic [NumRequesters-1:0]              req_ready;
  logic [NumRequesters-1:0]              req_write;
  logic [NumRequesters*AddressWidth-1:0] req_addr;
  logic [NumRequesters*DataWidth-1:0]    req_wdata;
  logic [NumRequesters*3-1:0]            req_size;
  logic [NumRequesters-1:0]              rsp_valid;
  logic [DataWidth-1:0]                  rsp_rdata;
  logic                                  rsp_error;
  logic [AddressWidth-1:0]               HADDR;
  logic                                  HWRITE;
  logic [2:0]                            HSIZE;
  logic [1:0]                            HTRANS;
  logic [DataWidth-1:0]                  HWDATA;
  logic [DataWidth-1:0]                  HRDATA;
  logic                                  HREADY;
  logic                                  HRESP;
`ifdef AHB_MANAGER_ARBITER_LOCK_EN
  logic [NumRequesters-1:0]              req_lock;
  logic                                  HMASTLOCK;
`endif

  modport master (
    input  req_valid, req_write, req_addr, req_wdata, req_size, HRDATA, HREADY, HRESP,
`ifdef AHB_MANAGER_ARBITER_LOCK_EN
    input  req_lock,
    output HMASTLOCK,
`endif
    output req_ready, rsp_valid, rsp_rdata, rsp_error,
    output HADDR, HWRITE, HSIZE, HTRANS, HWDATA
  );

  modport slave (
    output req_valid, req_write, req_addr, req_wdata, req_size, HRDATA, HREADY, HRESP,
`ifdef AHB_MANAGER_ARBITER_LOCK_EN
    output req_lock,
    input  HMASTLOCK,
`endif
    input  req_ready, rsp_valid, rsp_rdata, rsp_error,
    input  HADDR, HWRITE, HSIZE, HTRANS, HWDATA
  );
endinterface

// File: rtl/ahb_manager_arbiter.sv
// Round-robin AHB-Lite manager shared by NumRequesters clients, pipelined address/data phases.
// Optional locked sequences when AHB_MANAGER_ARBITER_LOCK_EN is defined.
`timescale 1ns/1ps
module ahb_manager_arbiter #(
  parameter int NumRequesters = 2,
  parameter int AddressWidth  = 32,
  parameter int DataWidth     = 32
) (
  input logic                   clk,
  input logic                   rst,
  ahb_manager_arbiter_if.master bus
);
  localparam int PW = (NumRequesters > 1) ? $clog2(NumRequesters) : 1;
  localparam logic [PW-1:0] PTR_RST = PW'(NumRequesters - 1);
  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

  logic [PW-1:0]              r_ptr;
  logic                       r_a_valid;
  logic [PW-1:0]              r_a_owner;
  logic                       r_a_write;
  logic [DataWidth-1:0]       r_a_wdata;
  logic [AddressWidth-1:0]    r_haddr;
  logic [2:0]                 r_hsize;
  logic                       r_d_valid;
  logic [PW-1:0]              r_d_owner;
  logic                       r_d_write;
  logic [DataWidth-1:0]       r_hwdata;
  logic [NumRequesters-1:0]   r_rsp_valid;
  logic [DataWidth-1:0]       r_rsp_rdata;
  logic                       r_rsp_error;

  logic                       w_slot_free;
  logic [NumRequesters-1:0]   w_elig;
  logic                       w_grant;
  logic [PW-1:0]              w_grant_idx;
  logic [NumRequesters-1:0]   w_ready;
  logic [NumRequesters-1:0]   w_d_onehot;
  int                         w_scan;

`ifdef AHB_MANAGER_ARBITER_LOCK_EN
  logic                       r_locked;
  logic [PW-1:0]              r_lock_owner;
  logic                       r_a_lock;
`endif

  assign w_slot_free = !r_a_valid || bus.HREADY;
  assign w_d_onehot  = NumRequesters'(1) << r_d_owner;

  // While a locked sequence is open only its owner may be granted.
  always_comb begin
    w_elig = bus.req_valid;
`ifdef AHB_MANAGER_ARBITER_LOCK_EN
    if (r_locked) w_elig = bus.req_valid & (NumRequesters'(1) << r_lock_owner);
`endif
  end

  always_comb begin
    w_grant     = 1'b0;
    w_grant_idx = '0;
    w_scan      = 0;
    for (int k = 1; k <= NumRequesters; k++) begin
      w_scan = int'(r_ptr) + k;
      if (w_scan >= NumRequesters) w_scan = w_scan - NumRequesters;
      if (!w_grant && w_elig[w_scan]) begin
        w_grant     = 1'b1;
        w_grant_idx = PW'(w_scan);
      end
    end
  end

  always_comb begin
    w_ready = '0;
    if (!rst && w_slot_free && w_grant) w_ready[w_grant_idx] = 1'b1;
  end

  // Address slot: loads whenever it is free, so an idle free slot drops back to IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr     <= PTR_RST;
      r_a_valid <= 1'b0;
      r_a_owner <= '0;
      r_a_write <= 1'b0;
      r_a_wdata <= '0;
      r_haddr   <= '0;
      r_hsize   <= '0;
    end else if (w_slot_free) begin
      r_a_valid <= w_grant;
      if (w_grant) begin
        r_ptr     <= w_grant_idx;
        r_a_owner <= w_grant_idx;
        r_a_write <= bus.req_write[w_grant_idx];
        r_a_wdata <= bus.req_wdata[int'(w_grant_idx)*DataWidth +: DataWidth];
        r_haddr   <= bus.req_addr[int'(w_grant_idx)*AddressWidth +: AddressWidth];
        r_hsize   <= bus.req_size[int'(w_grant_idx)*3 +: 3];
      end
    end
  end

`ifdef AHB_MANAGER_ARBITER_LOCK_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_locked     <= 1'b0;
      r_lock_owner <= '0;
      r_a_lock     <= 1'b0;
    end else if (w_slot_free) begin
      r_a_lock <= w_grant && bus.req_lock[w_grant_idx];
      if (w_grant) begin
        r_locked     <= bus.req_lock[w_grant_idx];
        r_lock_owner <= w_grant_idx;
      end
    end
  end

  assign bus.HMASTLOCK = r_a_lock;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_d_valid <= 1'b0;
      r_d_owner <= '0;
      r_d_write <= 1'b0;
      r_hwdata  <= '0;
    end else if (bus.HREADY) begin
      r_d_valid <= r_a_valid;
      if (r_a_valid) begin
        r_d_owner <= r_a_owner;
        r_d_write <= r_a_write;
        r_hwdata  <= r_a_wdata;
      end
    end
  end

  // Response pulse lands one cycle after the data phase completes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rsp_valid <= '0;
      r_rsp_rdata <= '0;
      r_rsp_error <= 1'b0;
    end else if (r_d_valid && bus.HREADY) begin
      r_rsp_valid <= w_d_onehot;
      r_rsp_rdata <= r_d_write ? '0 : bus.HRDATA;
      r_rsp_error <= bus.HRESP;
    end else begin
      r_rsp_valid <= '0;
      r_rsp_error <= 1'b0;
    end
  end

  assign bus.req_ready = w_ready;
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_rdata = r_rsp_rdata;
  assign bus.rsp_error = r_rsp_error;
  assign bus.HADDR     = r_haddr;
  assign bus.HWRITE    = r_a_write;
  assign bus.HSIZE     = r_hsize;
  assign bus.HTRANS    = r_a_valid ? HTRANS_NONSEQ : HTRANS_IDLE;
  assign bus.HWDATA    = r_hwdata;
endmodule

// File: tb/tb_ahb_manager_arbiter.sv
// Directed vector bench for ahb_manager_arbiter with two clients; one row per clock cycle.
`timescale 1ns/1ps
module tb_ahb_manager_arbiter;
  localparam int N  = 2;
  localparam int AW = 32;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ahb_manager_arbiter_if #(.NumRequesters(N), .AddressWidth(AW), .DataWidth(DW)) bus ();
  ahb_manager_arbiter #(.NumRequesters(N), .AddressWidth(AW), .DataWidth(DW)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  typedef struct {
    logic [1:0]  rv;
    logic [1:0]  wr;
    logic [31:0] a0, wd0, a1, wd1;
    logic        hr, hresp;
    logic [31:0] hrd;
    logic [1:0]  e_rdy;
    logic        e_nseq;
    logic [31:0] e_addr;
    logic        e_wr;
    logic [2:0]  e_sz;
    logic        cw;
    logic [31:0] e_wd;
    logic [1:0]  e_rv;
    logic [31:0] e_rd;
    logic        e_err;
  } vec_t;

  vec_t vecs[$];
  int checks = 0;
  int failures = 0;

  function automatic vec_t mk(logic [1:0] rv, logic [1:0] wr, logic [31:0] a0, logic [31:0] wd0,
                              logic [31:0] a1, logic [31:0] wd1, logic hr, logic hresp, logic [31:0] hrd,
                              logic [1:0] e_rdy, logic e_nseq, logic [31:0] e_addr, logic e_wr,
                              logic [2:0] e_sz, logic cw, logic [31:0] e_wd, logic [1:0] e_rv,
                              logic [31:0] e_rd, logic e_err);
    vec_t v;
    v.rv = rv; v.wr = wr; v.a0 = a0; v.wd0 = wd0; v.a1 = a1; v.wd1 = wd1;
    v.hr = hr; v.hresp = hresp; v.hrd = hrd;
    v.e_rdy = e_rdy; v.e_nseq = e_nseq; v.e_addr = e_addr; v.e_wr = e_wr; v.e_sz = e_sz;
    v.cw = cw; v.e_wd = e_wd; v.e_rv = e_rv; v.e_rd = e_rd; v.e_err = e_err;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic apply(input vec_t v);
    bus.req_valid = v.rv;
    bus.req_write = v.wr;
    bus.req_addr  = {v.a1, v.a0};
    bus.req_wdata = {v.wd1, v.wd0};
    bus.HREADY    = v.hr;
    bus.HRESP     = v.hresp;
    bus.HRDATA    = v.hrd;
  endtask

  task automatic check_row(input int i, input vec_t v);
    chk($sformatf("r%0d req_ready", i), 32'(bus.req_ready), 32'(v.e_rdy));
    chk($sformatf("r%0d htrans", i), 32'(bus.HTRANS), v.e_nseq ? 32'd2 : 32'd0);
    chk($sformatf("r%0d rsp_valid", i), 32'(bus.rsp_valid), 32'(v.e_rv));
    if (v.e_nseq) begin
      chk($sformatf("r%0d haddr", i), bus.HADDR, v.e_addr);
      chk($sformatf("r%0d hwrite", i), 32'(bus.HWRITE), 32'(v.e_wr));
      chk($sformatf("r%0d hsize", i), 32'(bus.HSIZE), 32'(v.e_sz));
    end
    if (v.cw) chk($sformatf("r%0d hwdata", i), bus.HWDATA, v.e_wd);
    if (v.e_rv != 2'b00) begin
      chk($sformatf("r%0d rsp_rdata", i), bus.rsp_rdata, v.e_rd);
      chk($sformatf("r%0d rsp_error", i), 32'(bus.rsp_error), 32'(v.e_err));
    end
  endtask

  task automatic cycle_in(input logic [1:0] rv, input logic [31:0] a0, input logic [31:0] a1);
    @(posedge clk); #1;
    bus.req_valid = rv;
    bus.req_addr  = {a1, a0};
    #2;
  endtask

  initial begin
    // Client 0 uses HSIZE=word, client 1 halfword, so HSIZE identifies the owner.
    bus.req_size  = {3'd1, 3'd2};
    bus.req_valid = 2'b11;
    bus.req_write = '0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    bus.HREADY    = 1'b1;
    bus.HRESP     = 1'b0;
    bus.HRDATA    = '0;
`ifdef AHB_MANAGER_ARBITER_LOCK_EN
    bus.req_lock  = '0;
`endif
    rst = 1'b1;

    // both clients write, accepts alternate 0,1,0,1
    vecs.push_back(mk(2'b11, 2'b11, 'h10, 'hA0, 'h20, 'hB1, 1, 0, 0, 2'b01, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0));
    vecs.push_back(mk(2'b11, 2'b11, 'h10, 'hA0, 'h20, 'hB1, 1, 0, 0, 2'b10, 1, 'h10, 1, 2, 0, 0, 2'b00, 0, 0));
    vecs.push_back(mk(2'b11, 2'b11, 'h10, 'hA0, 'h20, 'hB1, 1, 0, 0, 2'b01, 1, 'h20, 1, 1, 1, 'hA0, 2'b00, 0, 0));
    vecs.push_back(mk(2'b11, 2'b11, 'h10, 'hA0, 'h20, 'hB1, 1, 0, 0, 2'b10, 1, 'h10, 1, 2, 1, 'hB1, 2'b01, 0, 0));
    vecs.push_back(mk(2'b00, 2'b11, 'h10, 'hA0, 'h20, 'hB1, 1, 0, 0, 2'b00, 1, 'h20, 1, 1, 1, 'hA0, 2'b10, 0, 0));
    vecs.push_back(mk(2'b00, 2'b00, 0, 0, 0, 0, 1, 0, 0, 2'b00, 0, 0, 0, 0, 1, 'hB1, 2'b01, 0, 0));
    vecs.push_back(mk(2'b00, 2'b00, 0, 0, 0, 0, 1, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 2'b10, 0, 0));
    vecs.push_back(mk(2'b00, 2'b00, 0, 0, 0, 0, 1, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0));
    // client 0 single read, zero wait states
    vecs.push_back(mk(2'b01, 2'b00, 'h1000, 0, 0, 0, 1, 0, 0, 2'b01, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0));
    vecs.push_back(mk(2'b00, 2'b00, 'h1000, 0, 0, 0, 1, 0, 0, 2'b00, 1, 'h1000, 0, 2, 0, 0, 2'b00, 0, 0));
    vecs.push_back(mk(2'b00, 2'b00, 0, 0, 0, 0, 1, 0, 'hDEADBEEF, 2'b00, 0, 0, 0, 0, 1, 0, 2'b00, 0, 0));
    vecs.push_back(mk(2'b00, 2'b00, 0, 0, 0, 0, 1, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 2'b01, 'hDEADBEEF, 0));
    // write 0x40 with three wait states in its data phase, read 0x44 queued behind
    vecs.push_back(mk(2'b10, 2'b10, 0, 0, 'h40, 'h55, 1, 0, 0, 2'b10, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0));
    vecs.push_back(mk(2'b01, 2'b00, 'h44, 0, 'h40, 'h55, 1, 0, 0, 2'b01, 1, 'h40, 1, 1, 0, 0, 2'b00, 0, 0));
    vecs.push_back(mk(2'b10, 2'b10, 'h44, 0, 'h48, 'h66, 0, 0, 0, 2'b00, 1, 'h44, 0, 2, 1, 'h55, 2'b00, 0, 0));
    vecs.push_back(mk(2'b10, 2'b10, 'h44, 0, 'h48, 'h66, 0, 0, 0, 2'b00, 1, 'h44, 0, 2, 1, 'h55, 2'b00, 0, 0));
    vecs.push_back(mk(2'b10, 2'b10, 'h44, 0, 'h48, 'h66, 0, 0, 0, 2'b00, 1, 'h44, 0, 2, 1, 'h55, 2'b00, 0, 0));
    vecs.push_back(mk(2'b10, 2'b10, 'h44, 0, 'h48, 'h66, 1, 0, 0, 2'b10, 1, 'h44, 0, 2, 1, 'h55, 2'b00, 0, 0));
    vecs.push_back(mk(2'b00, 2'b10, 'h44, 0, 'h48, 'h66, 1, 0, 'h12345678, 2'b00, 1, 'h48, 1, 1, 1, 0, 2'b10, 0, 0));
    vecs.push_back(mk(2'b00, 2'b00, 0, 0, 0, 0, 1, 0, 0, 2'b00, 0, 0, 0, 0, 1, 'h66, 2'b01, 'h12345678, 0));
    vecs.push_back(mk(2'b00, 2'b00, 0, 0, 0, 0, 1, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 2'b10, 0, 0));
    vecs.push_back(mk(2'b00, 2'b00, 0, 0, 0, 0, 1, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0));
    // two-cycle ERROR on read 0x80, queued write 0x90 completes normally
    vecs.push_back(mk(2'b11, 2'b10, 'h80, 0, 'h90, 'h77, 1, 0, 0, 2'b01, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0));
    vecs.push_back(mk(2'b10, 2'b10, 'h80, 0, 'h90, 'h77, 1, 0, 0, 2'b10, 1, 'h80, 0, 2, 0, 0, 2'b00, 0, 0));
    vecs.push_back(mk(2'b00, 2'b10, 'h80, 0, 'h90, 'h77, 0, 1, 0, 2'b00, 1, 'h90, 1, 1, 1, 0, 2'b00, 0, 0));
    vecs.push_back(mk(2'b00, 2'b10, 'h80, 0, 'h90, 'h77, 1, 1, 'hBAD0, 2'b00, 1, 'h90, 1, 1, 1, 0, 2'b00, 0, 0));
    vecs.push_back(mk(2'b00, 2'b00, 0, 0, 0, 0, 1, 0, 0, 2'b00, 0, 0, 0, 0, 1, 'h77, 2'b01, 'hBAD0, 1));
    vecs.push_back(mk(2'b00, 2'b00, 0, 0, 0, 0, 1, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 2'b10, 0, 0));
    vecs.push_back(mk(2'b00, 2'b00, 0, 0, 0, 0, 1, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0));

    // reset values, with requests pending while rst is high
    repeat (2) @(posedge clk);
    #3;
    chk("rst req_ready", 32'(bus.req_ready), 32'd0);
    chk("rst htrans", 32'(bus.HTRANS), 32'd0);
    chk("rst haddr", bus.HADDR, 32'd0);
    chk("rst hwrite", 32'(bus.HWRITE), 32'd0);
    chk("rst hsize", 32'(bus.HSIZE), 32'd0);
    chk("rst hwdata", bus.HWDATA, 32'd0);
    chk("rst rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("rst rsp_rdata", bus.rsp_rdata, 32'd0);
    chk("rst rsp_error", 32'(bus.rsp_error), 32'd0);
    #2;
    bus.req_valid = 2'b00;
    rst = 1'b0;

    foreach (vecs[i]) begin
      @(posedge clk); #1;
      apply(vecs[i]);
      #2;
      check_row(i, vecs[i]);
    end

    // reset in the middle of a streaming cycle
    bus.req_write = 2'b11;
    bus.req_wdata = {32'hB1, 32'hA0};
    cycle_in(2'b11, 'h10, 'h20);
    cycle_in(2'b11, 'h10, 'h20);
    cycle_in(2'b11, 'h10, 'h20);
    cycle_in(2'b11, 'h10, 'h20);
    chk("pre-rst htrans", 32'(bus.HTRANS), 32'd2);
    chk("pre-rst rsp_valid", 32'(bus.rsp_valid), 32'd1);
    chk("pre-rst hsize", 32'(bus.HSIZE), 32'd2);
    rst = 1'b1;
    #1;
    chk("mid-rst htrans", 32'(bus.HTRANS), 32'd0);
    chk("mid-rst rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("mid-rst req_ready", 32'(bus.req_ready), 32'd0);
    chk("mid-rst haddr", bus.HADDR, 32'd0);
    chk("mid-rst hwdata", bus.HWDATA, 32'd0);
    #1;
    rst = 1'b0;
    #1;
    chk("post-rst first grant", 32'(bus.req_ready), 32'd1);
    bus.req_valid = 2'b00;
    repeat (3) @(posedge clk);

`ifdef AHB_MANAGER_ARBITER_LOCK_EN
    // client 1 locks three writes, client 0 starved until the unlocked one is accepted
    bus.req_lock = 2'b10;
    cycle_in(2'b10, 'hD0, 'hC0);
    chk("lock0 req_ready", 32'(bus.req_ready), 32'd2);
    cycle_in(2'b11, 'hD0, 'hC4);
    chk("lock1 req_ready", 32'(bus.req_ready), 32'd2);
    chk("lock1 hmastlock", 32'(bus.HMASTLOCK), 32'd1);
    cycle_in(2'b11, 'hD0, 'hC8);
    chk("lock2 req_ready", 32'(bus.req_ready), 32'd2);
    chk("lock2 hmastlock", 32'(bus.HMASTLOCK), 32'd1);
    bus.req_lock = 2'b00;
    cycle_in(2'b11, 'hD0, 'hCC);
    chk("lock3 req_ready", 32'(bus.req_ready), 32'd2);
    chk("lock3 hmastlock", 32'(bus.HMASTLOCK), 32'd1);
    cycle_in(2'b01, 'hD0, 'hCC);
    chk("unlock req_ready", 32'(bus.req_ready), 32'd1);
    chk("unlock hmastlock", 32'(bus.HMASTLOCK), 32'd0);
    cycle_in(2'b00, 'hD0, 'hCC);
    chk("unlock haddr", bus.HADDR, 32'hD0);
    chk("unlock hmastlock2", 32'(bus.HMASTLOCK), 32'd0);
    repeat (4) @(posedge clk);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/ahb_manager_arbiter.md
Name: ahb_manager_arbiter

Overview:
- Shares one AHB-Lite manager port among NumRequesters simple request/response clients.
- Uses round-robin arbitration and single NONSEQ transfers.
- Pipelines transfers: the address phase of the next transfer overlaps the data phase of the current one, and HREADY wait states are honoured.
- Drives the renode_ahb_if manager-side signals in simulation tops; the Renode AHB subordinate is the bus target.

Parameters:
NumRequesters, 2, number of clients (1..8)
AddressWidth, 32, HADDR/req_addr width
DataWidth, 32, HWDATA/HRDATA/req_wdata/rsp_rdata width

Ports:
clk  in  1  bus clock; all logic on posedge
rst  in  1  asynchronous active-high reset
req_valid  in  NumRequesters  per-client request pending
req_ready  out  NumRequesters  per-client accept, one-hot or zero
req_write  in  NumRequesters  1=write
req_addr  in  NumRequesters*AddressWidth  packed, client i at [i*AW +: AW]
req_wdata  in  NumRequesters*DataWidth  packed write data
req_size  in  NumRequesters*3  packed HSIZE encoding
rsp_valid  out  NumRequesters  one-cycle pulse to owning client on data-phase completion
rsp_rdata  out  DataWidth  read data, valid with rsp_valid
rsp_error  out  1  1 = transfer completed with HRESP=ERROR
HADDR  out  AddressWidth  AHB address
HWRITE  out  1  AHB direction
HSIZE  out  3  AHB size
HTRANS  out  2  IDLE(00) or NONSEQ(10) only
HWDATA  out  DataWidth  AHB write data
HRDATA  in  DataWidth  AHB read data
HREADY  in  1  AHB ready
HRESP  in  1  AHB response

Behaviour:
- Reset (async): HTRANS=IDLE; HADDR, HWRITE, HSIZE, HWDATA = 0; rsp_valid=0; rsp_rdata=0; rsp_error=0; addr/data phase slots empty; RR pointer = NumRequesters-1, so client 0 wins first. req_ready=0 while rst is high.
- Address slot register a_valid, a_owner, a_write, a_wdata.
  - HTRANS=NONSEQ iff a_valid; HADDR/HWRITE/HSIZE are registered.
  - Slot is free iff !a_valid || HREADY.
- Arbitration is combinational each cycle.
  - When the slot is free, scan from pointer+1 with wrap-around for the first client with req_valid; assert req_ready for that client only.
  - On posedge with req_valid&req_ready: load the address slot and set pointer = granted index.
  - With no request and a free slot: a_valid<=0, so HTRANS=IDLE next cycle.
- Address phase completes at posedge with a_valid && HREADY; the transfer moves to the data slot: d_valid, d_owner, d_write. HWDATA <= a_wdata at that edge.
- Data phase completes at posedge with d_valid && HREADY.
  - Next cycle: rsp_valid[d_owner]=1, rsp_rdata = HRDATA sampled (0 for writes), rsp_error = HRESP sampled.
  - d_valid clears unless a new address phase moved in at the same edge.
- Simultaneous events: the same edge may complete a data phase, promote an address phase and accept a new request. All three happen, giving one transfer per cycle at zero wait states.
- Latency: accept at edge N → NONSEQ during cycle N+1 → data phase cycle N+2 → rsp_valid cycle N+3, with zero wait states.
- HREADY low: every slot, HADDR, HWDATA and HTRANS are held; req_ready=0 while a_valid.
- ERROR: the first cycle (HRESP=1, HREADY=0) is a wait; completion is sampled on the second cycle. The pending address phase is not cancelled.
- Client requests are held stable by the client until accepted; the arbiter does not check this.

Optional Feature:
Macro AHB_MANAGER_ARBITER_LOCK_EN.
- When defined:
  - Adds input req_lock[NumRequesters] and output HMASTLOCK.
  - After client i is accepted with req_lock[i]=1, arbitration grants only client i until a transfer from i is accepted with req_lock[i]=0.
  - HMASTLOCK equals the registered lock bit of the address slot.
- When undefined: neither port exists and arbitration is pure round-robin.

Test Plan:
- Client 0 reads 0x1000, HRDATA=0xDEADBEEF, HREADY=1 → NONSEQ one cycle after accept; rsp_valid[0] 3 cycles after accept; rsp_rdata=0xDEADBEEF; rsp_error=0.
- Both clients hold req_valid with writes to 0x10/0x20 → accepts alternate 0,1,0,1; HTRANS stays NONSEQ back-to-back; HWDATA follows HADDR by one cycle.
- Write to 0x40 with data 0x55, HREADY low 3 cycles in its data phase → HADDR of the next transfer and HWDATA=0x55 held; no req_ready; single rsp_valid after HREADY rises.
- Two-cycle ERROR on read of 0x80 → rsp_error=1 with rsp_valid; the following queued transfer still completes normally.
- rst asserted mid-transfer, between clock edges → HTRANS=IDLE and rsp_valid=0 immediately; after release, client 0 is granted first.
- LOCK_EN: client 1 issues 3 locked writes while client 0 requests → HMASTLOCK=1 and client 0 is starved until client 1's unlocked transfer is accepted.
